// File: rtl/oai_n1_pipe_pkg.sv
// Shared definitions for the oai_n1_pipe macro: the per-lane OAI(N)1
// function, the data-register reset value and the legal parameter ranges.
package oai_n1_pipe_pkg;

   localparam int W_MIN       = 1;
   localparam int W_MAX       = 32;
   localparam int N_MIN       = 2;
   localparam int N_MAX       = 4;
   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 4;

   // Data registers reset to all-ones; callers slice the width they need.
   localparam logic [W_MAX-1:0] ZN_RST = '1;

   // One lane: ~((a[0] | ... | a[N-1]) & b). The OR group is passed
   // zero-padded to N_MAX bits, so unused upper bits do not disturb the OR.
   function automatic logic oai_n1_f(input logic [N_MAX-1:0] a, input logic b);
      return ~((|a) & b);
   endfunction

endpackage

// File: rtl/oai_n1_pipe_stage.sv
// One stallable pipeline stage: W data bits plus a valid bit.
// Priority: reset, then scan shift, then advance, otherwise hold.
// In scan mode the stage is a (W+1)-bit shift register ordered
// valid, data[0] .. data[W-1]; si_i enters at valid, data[W-1] is the
// bit handed to the next stage.
module oai_n1_pipe_stage
   import oai_n1_pipe_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   input  logic         se_i,
   input  logic         si_i,
   input  logic [W-1:0] d_i,
   input  logic         v_i,
   output logic [W-1:0] q_o,
   output logic         vq_o
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   // Next-state select: scan shift overrides the functional enable.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (se_i) begin
         data_d  = (data_q << 1) | W'(valid_q);
         valid_d = si_i;
      end else if (en_i) begin
         data_d  = d_i;
         valid_d = v_i;
      end
   end

   // Stage registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         data_q  <= ZN_RST[W-1:0];
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q_o  = data_q;
   assign vq_o = valid_q;

endmodule

// File: rtl/oai_n1_pipe.sv
// oai_n1_pipe: W lanes of ZN[i] = ~(|A[i*N +: N] & B[i]) followed by a
// LATENCY-deep stallable register pipeline with a travelling valid bit.
// Build options:
//   OAI_N1_PIPE_SCAN_EN - adds SE/SI/SO; all stage registers form one
//                         scan chain (length LATENCY*(W+1)).
//   USE_POWER_PINS      - adds VDD/VSS pins (no logic attached).
// ZN and VZ come straight from the last stage registers.
module oai_n1_pipe
   import oai_n1_pipe_pkg::*;
#(
   parameter int W       = 4,
   parameter int N       = 3,
   parameter int LATENCY = 1
) (
`ifdef USE_POWER_PINS
   inout  wire            VDD,
   inout  wire            VSS,
`endif
   input  logic           CLK,
   input  logic           RN,
   input  logic           E,
   input  logic           V,
   input  logic [W*N-1:0] A,
   input  logic [W-1:0]   B,
`ifdef OAI_N1_PIPE_SCAN_EN
   input  logic           SE,
   input  logic           SI,
   output logic           SO,
`endif
   output logic [W-1:0]   ZN,
   output logic           VZ
);

   if (W < W_MIN || W > W_MAX || N < N_MIN || N > N_MAX ||
       LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_param_err
      $error("oai_n1_pipe: parameter out of range");
   end

   logic [W-1:0] f_s;
   logic         se_s;
   logic         si_s;

   // Stage-0 value: one OAI(N)1 per lane.
   for (genvar i = 0; i < W; i++) begin : g_lane
      assign f_s[i] = oai_n1_f(N_MAX'(A[i*N +: N]), B[i]);
   end

`ifdef OAI_N1_PIPE_SCAN_EN
   assign se_s = SE;
   assign si_s = SI;
   assign SO   = ZN[W-1];
`else
   assign se_s = 1'b0;
   assign si_s = 1'b0;
`endif

   logic [W-1:0] d_s [LATENCY+1];
   logic         v_s [LATENCY+1];
   logic         s_s [LATENCY];

   assign d_s[0] = f_s;
   assign v_s[0] = V;
   assign s_s[0] = si_s;

   // Scan chain continues from each stage's top data bit into the next valid.
   for (genvar k = 1; k < LATENCY; k++) begin : g_scan_link
      assign s_s[k] = d_s[k][W-1];
   end

   for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
      oai_n1_pipe_stage #(.W(W)) u_stage (
         .clk_i   (CLK),
         .rst_n_i (RN),
         .en_i    (E),
         .se_i    (se_s),
         .si_i    (s_s[k-1]),
         .d_i     (d_s[k-1]),
         .v_i     (v_s[k-1]),
         .q_o     (d_s[k]),
         .vq_o    (v_s[k])
      );
   end

   assign ZN = d_s[LATENCY];
   assign VZ = v_s[LATENCY];

endmodule

// File: tb/tb_oai_n1_pipe.sv
// Bench for oai_n1_pipe with three instances:
//   u_a: W=4 N=3 LATENCY=3  (reset, latency/stall, valid tracking)
//   u_b: W=1 N=3 LATENCY=1  (OAI31 truth table, E toggling)
//   u_c: W=2 N=3 LATENCY=2  (reset mid-flight, RN glitch, scan)
module tb_oai_n1_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic        rn_a, e_a, v_a;
   logic [11:0] a_a;
   logic [3:0]  b_a;
   logic [3:0]  zn_a;
   logic        vz_a;

   logic        rn_b, e_b, v_b;
   logic [2:0]  a_b;
   logic        b_b;
   logic        zn_b;
   logic        vz_b;

   logic        rn_c, e_c, v_c;
   logic [5:0]  a_c;
   logic [1:0]  b_c;
   logic [1:0]  zn_c;
   logic        vz_c;

`ifdef OAI_N1_PIPE_SCAN_EN
   logic        so_a, so_b, so_c;
   logic        se_c, si_c;
   logic        scan_q [$];
   logic [5:0]  sbits;
`endif

   oai_n1_pipe #(.W(4), .N(3), .LATENCY(3)) u_a (
      .CLK(clk), .RN(rn_a), .E(e_a), .V(v_a), .A(a_a), .B(b_a),
`ifdef OAI_N1_PIPE_SCAN_EN
      .SE(1'b0), .SI(1'b0), .SO(so_a),
`endif
      .ZN(zn_a), .VZ(vz_a));

   oai_n1_pipe #(.W(1), .N(3), .LATENCY(1)) u_b (
      .CLK(clk), .RN(rn_b), .E(e_b), .V(v_b), .A(a_b), .B(b_b),
`ifdef OAI_N1_PIPE_SCAN_EN
      .SE(1'b0), .SI(1'b0), .SO(so_b),
`endif
      .ZN(zn_b), .VZ(vz_b));

   oai_n1_pipe #(.W(2), .N(3), .LATENCY(2)) u_c (
      .CLK(clk), .RN(rn_c), .E(e_c), .V(v_c), .A(a_c), .B(b_c),
`ifdef OAI_N1_PIPE_SCAN_EN
      .SE(se_c), .SI(si_c), .SO(so_c),
`endif
      .ZN(zn_c), .VZ(vz_c));

   typedef struct {
      logic [2:0] a;
      logic       b;
      logic       zn;
   } tt_vec_t;

   typedef struct {
      logic [3:0] zn;
      logic       vz;
   } out_t;

   tt_vec_t    tt [16];
   logic       sb_b [$];
   logic [3:0] sb_a [$];
   out_t       q_vt [$];

   logic [2:0] tog_a [4] = '{3'b001, 3'b000, 3'b000, 3'b111};
   logic       tog_e [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic       tog_z [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   // Reference: a lane output is 0 only when its B is 1 and some A bit is set.
   function automatic logic [31:0] model_f(input logic [127:0] a, input logic [31:0] b,
                                           input int w);
      logic [31:0] r;
      r = '1;
      for (int i = 0; i < w; i++)
         if (b[i] && (a[i*3 +: 3] != 3'b000)) r[i] = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // X on E is not allowed.
   always @(posedge clk) begin
      if ($isunknown({e_a, e_b, e_c})) begin
         fails++;
         $display("FAIL e_known: E is X/Z at %0t", $time);
      end
   end

   // Drive one valid item into u_a, optionally stall, and time its arrival.
   task automatic send_and_time_a(input int stall_start, input int stall_len, output int n);
      logic [31:0] m;
      v_a = 1'b1; e_a = 1'b1; a_a = 12'h001; b_a = 4'h1;
      m = model_f(128'(a_a), 32'(b_a), 4);
      sb_a.push_back(m[3:0]);
      step();
      v_a = 1'b0; a_a = '0; b_a = '0;
      n = -1;
      for (int c = 2; c <= 12; c++) begin
         e_a = (c >= stall_start && c < stall_start + stall_len) ? 1'b0 : 1'b1;
         step();
         if (vz_a === 1'b1) begin
            n = c;
            break;
         end
      end
      e_a = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] m;
      out_t        o;

      rn_a = 1'b0; e_a = 1'b1; v_a = 1'b1; a_a = '1; b_a = '1;
      rn_b = 1'b0; e_b = 1'b1; v_b = 1'b1; a_b = '1; b_b = 1'b1;
      rn_c = 1'b0; e_c = 1'b1; v_c = 1'b1; a_c = '1; b_c = '1;
`ifdef OAI_N1_PIPE_SCAN_EN
      se_c = 1'b0; si_c = 1'b0;
`endif

      // Reset: one edge with RN=0 and everything else active.
      step();
      chk("rst_zn", 32'(zn_a), 32'hF);
      chk("rst_vz", 32'(vz_a), 32'h0);
      a_a = 12'h249; b_a = 4'hF; v_a = 1'b0; e_a = 1'b0;
      step();
      chk("rst_hold_zn", 32'(zn_a), 32'hF);
      chk("rst_hold_vz", 32'(vz_a), 32'h0);

      rn_a = 1'b1; e_a = 1'b1; v_a = 1'b0; a_a = '0; b_a = '0;
      rn_b = 1'b1; e_b = 1'b1; v_b = 1'b0; a_b = '0; b_b = 1'b0;
      rn_c = 1'b1; e_c = 1'b1; v_c = 1'b0; a_c = '0; b_c = '0;

      // Truth table of the W=1, N=3, LATENCY=1 instance (OAI31).
      for (int i = 0; i < 16; i++) begin
         tt[i].a  = 3'(i >> 1);
         tt[i].b  = i[0];
         tt[i].zn = (tt[i].b && tt[i].a != 3'b000) ? 1'b0 : 1'b1;
      end
      for (int i = 0; i < 16; i++) begin
         a_b = tt[i].a; b_b = tt[i].b; v_b = 1'b1; e_b = 1'b1;
         sb_b.push_back(tt[i].zn);
         step();
         chk("tt_vz", 32'(vz_b), 32'h1);
         if (vz_b === 1'b1 && sb_b.size() > 0) chk($sformatf("tt_zn[%0d]", i), 32'(zn_b), 32'(sb_b.pop_front()));
      end
      v_b = 1'b0;

      // E toggling: ZN only moves on E=1 edges.
      for (int i = 0; i < 4; i++) begin
         a_b = tog_a[i]; b_b = 1'b1; e_b = tog_e[i];
         step();
         chk($sformatf("etog_zn[%0d]", i), 32'(zn_b), 32'(tog_z[i]));
      end
      e_b = 1'b1;

      // Latency without stall, then with a 2-cycle stall mid-flight.
      for (int i = 0; i < 4; i++) step();
      send_and_time_a(100, 0, n);
      chk("lat_nostall", 32'(n), 32'd3);
      if (vz_a === 1'b1 && sb_a.size() > 0) chk("lat_nostall_zn", 32'(zn_a), 32'(sb_a.pop_front()));
      for (int i = 0; i < 4; i++) step();
      send_and_time_a(2, 2, n);
      chk("lat_stall", 32'(n), 32'd5);
      if (vz_a === 1'b1 && sb_a.size() > 0) chk("lat_stall_zn", 32'(zn_a), 32'(sb_a.pop_front()));

      // Valid tracking: alternating V, ZN checked on every cycle.
      for (int i = 0; i < 4; i++) step();
      for (int t = 0; t < 12; t++) begin
         if (t < 10) begin
            v_a = (t % 2 == 0);
            a_a = 12'($urandom);
            b_a = 4'($urandom);
         end else begin
            v_a = 1'b0; a_a = '0; b_a = '0;
         end
         m    = model_f(128'(a_a), 32'(b_a), 4);
         o.zn = m[3:0];
         o.vz = v_a;
         q_vt.push_back(o);
         step();
         if (t >= 2) begin
            o = q_vt.pop_front();
            chk($sformatf("vt_zn[%0d]", t), 32'(zn_a), 32'(o.zn));
            chk($sformatf("vt_vz[%0d]", t), 32'(vz_a), 32'(o.vz));
         end
      end
      q_vt.delete();

      // Reset mid-flight on u_c: in-flight items are discarded.
      step(); step();
      v_c = 1'b1; a_c = 6'b001_001; b_c = 2'b11;
      step();
      a_c = 6'b010_100; rn_c = 1'b0;
      step();
      chk("midrst_zn", 32'(zn_c), 32'h3);
      chk("midrst_vz", 32'(vz_c), 32'h0);
      rn_c = 1'b1; v_c = 1'b0; a_c = '0; b_c = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("midrst_after_vz[%0d]", i), 32'(vz_c), 32'h0);
         chk($sformatf("midrst_after_zn[%0d]", i), 32'(zn_c), 32'h3);
      end

      // RN pulsing low between edges must not disturb the pipeline.
      v_c = 1'b1; a_c = 6'b001_000; b_c = 2'b11;
      m = model_f(128'(a_c), 32'(b_c), 2);
      step();
      v_c = 1'b0; a_c = '0; b_c = '0;
      #2 rn_c = 1'b0;
      #2 rn_c = 1'b1;
      step();
      chk("rnglitch_vz", 32'(vz_c), 32'h1);
      chk("rnglitch_zn", 32'(zn_c), 32'(m[1:0]));

`ifdef OAI_N1_PIPE_SCAN_EN
      // Scan: 6-bit chain, bits appear on SO in shift-in order.
      sbits = 6'b101100;
      e_c = 1'b0; se_c = 1'b1;
      for (int t = 1; t <= 11; t++) begin
         if (t <= 6) begin
            si_c = sbits[6-t];
            scan_q.push_back(si_c);
         end else begin
            si_c = 1'b0;
         end
         step();
         if (t >= 6 && scan_q.size() > 0) chk($sformatf("scan_so[%0d]", t), 32'(so_c), 32'(scan_q.pop_front()));
      end
      se_c = 1'b0; e_c = 1'b1; v_c = 1'b1; a_c = 6'b000_001; b_c = 2'b01;
      m = model_f(128'(a_c), 32'(b_c), 2);
      step();
      v_c = 1'b0; a_c = '0; b_c = '0;
      step();
      chk("scan_resume_vz", 32'(vz_c), 32'h1);
      chk("scan_resume_zn", 32'(zn_c), 32'(m[1:0]));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
